// File: rtl/hmc6502_pkg.sv
// Shared definitions for the 6502-subset subsystem: opcodes, FSM states,
// status-register bit positions, memory map and flag helpers.
package hmc6502_pkg;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_STA_ZP  = 8'h85;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_TXA     = 8'h8A;
  localparam logic [7:0] OP_TXS     = 8'h9A;
  localparam logic [7:0] OP_TSX     = 8'hBA;
  localparam logic [7:0] OP_PHA     = 8'h48;
  localparam logic [7:0] OP_PLA     = 8'h68;
  localparam logic [7:0] OP_PHP     = 8'h08;
  localparam logic [7:0] OP_PLP     = 8'h28;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_NOP     = 8'hEA;

  typedef enum logic [2:0] {
    RESET0, RESET1, FETCH, OPER_LO, OPER_HI, STACK_INC, STACK_RW, EXEC
  } state_t;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_5 = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam logic [7:0]  RESET_P    = 8'h24;
  localparam logic [15:0] VEC_RST_LO = 16'hFFFC;
  localparam logic [15:0] VEC_RST_HI = 16'hFFFD;
  localparam logic [15:0] ROM_BASE   = 16'hF000;
  localparam logic [7:0]  STACK_PAGE = 8'h01;

  function automatic logic [7:0] set_nz(input logic [7:0] p, input logic [7:0] v);
    logic [7:0] r;
    r      = p;
    r[P_N] = v[7];
    r[P_Z] = (v == 8'h00);
    return r;
  endfunction

  // P as seen on the stack always has B and bit 5 set
  function automatic logic [7:0] push_p(input logic [7:0] p);
    logic [7:0] r;
    r      = p;
    r[P_B] = 1'b1;
    r[P_5] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] pull_p(input logic [7:0] v);
    logic [7:0] r;
    r      = v;
    r[P_B] = 1'b0;
    r[P_5] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/top_core.sv
// Multi-cycle 8-bit core: load/store, register transfers and page-$01 stack.
module hmc6502_core
  import hmc6502_pkg::*;
#(
  parameter logic [7:0] RESET_SP = 8'hFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rdata,
  output logic [15:0] o_addr,
  output logic        o_we,
  output logic [7:0]  o_wdata
);
  state_t      r_state;
  logic [7:0]  r_a, r_x, r_s, r_p, r_op, r_adl, r_adh;
  logic [15:0] r_pc;

  logic [15:0] w_pc_inc, w_stack_addr;
  logic        w_we, w_push;
  assign w_pc_inc     = r_pc + 16'd1;
  assign w_stack_addr = {STACK_PAGE, r_s};
  assign w_push       = (r_op == OP_PHA) || (r_op == OP_PHP);

  always_comb begin
    o_addr  = r_pc;
    o_wdata = r_a;
    w_we    = 1'b0;
    case (r_state)
      RESET0: o_addr = VEC_RST_LO;
      RESET1: o_addr = VEC_RST_HI;
      EXEC: begin
        if (r_op == OP_LDA_ZP || r_op == OP_STA_ZP) o_addr = {8'h00, r_adl};
        else if (r_op == OP_STA_ABS)                o_addr = {r_adh, r_adl};
        w_we = (r_op == OP_STA_ZP) || (r_op == OP_STA_ABS);
      end
      STACK_INC: o_addr = w_stack_addr;
      STACK_RW: begin
        o_addr  = w_stack_addr;
        w_we    = w_push;
        o_wdata = (r_op == OP_PHP) ? push_p(r_p) : r_a;
      end
      default: ;
    endcase
  end

  // Reset is async, so gating here kills a write in the very cycle it drops
  assign o_we = w_we & i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RESET0;
      r_a     <= 8'h00;
      r_x     <= 8'h00;
      r_s     <= RESET_SP;
      r_p     <= RESET_P;
      r_pc    <= 16'h0000;
      r_op    <= 8'h00;
      r_adl   <= 8'h00;
      r_adh   <= 8'h00;
    end else begin
      case (r_state)
        RESET0: begin r_pc[7:0]  <= i_rdata; r_state <= RESET1; end
        RESET1: begin r_pc[15:8] <= i_rdata; r_state <= FETCH;  end
        FETCH: begin
          r_op <= i_rdata;
          r_pc <= w_pc_inc;
          case (i_rdata)
            OP_LDA_IMM, OP_LDX_IMM, OP_LDA_ZP,
            OP_STA_ZP, OP_STA_ABS, OP_JMP_ABS: r_state <= OPER_LO;
            default:                           r_state <= EXEC;
          endcase
        end
        OPER_LO: begin
          r_adl <= i_rdata;
          r_pc  <= w_pc_inc;
          case (r_op)
            OP_LDA_IMM: begin r_a <= i_rdata; r_p <= set_nz(r_p, i_rdata); r_state <= FETCH; end
            OP_LDX_IMM: begin r_x <= i_rdata; r_p <= set_nz(r_p, i_rdata); r_state <= FETCH; end
            OP_STA_ABS, OP_JMP_ABS: r_state <= OPER_HI;
            default:                r_state <= EXEC;
          endcase
        end
        OPER_HI: begin
          r_adh <= i_rdata;
          if (r_op == OP_JMP_ABS) begin
            r_pc    <= {i_rdata, r_adl};
            r_state <= FETCH;
          end else begin
            r_pc    <= w_pc_inc;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_state <= FETCH;
          case (r_op)
            OP_LDA_ZP: begin r_a <= i_rdata; r_p <= set_nz(r_p, i_rdata); end
            OP_TAX:    begin r_x <= r_a;     r_p <= set_nz(r_p, r_a);     end
            OP_TXA:    begin r_a <= r_x;     r_p <= set_nz(r_p, r_x);     end
            OP_TXS:    r_s <= r_x;
            OP_TSX:    begin r_x <= r_s;     r_p <= set_nz(r_p, r_s);     end
            OP_PHA, OP_PHP: r_state <= STACK_RW;
            OP_PLA, OP_PLP: r_state <= STACK_INC;
            default: ;
          endcase
        end
        STACK_INC: begin r_s <= r_s + 8'd1; r_state <= STACK_RW; end
        STACK_RW: begin
          r_state <= FETCH;
          case (r_op)
            OP_PHA, OP_PHP: r_s <= r_s - 8'd1;
            OP_PLA: begin r_a <= i_rdata; r_p <= set_nz(r_p, i_rdata); end
            OP_PLP: r_p <= pull_p(i_rdata);
            default: ;
          endcase
        end
        default: r_state <= RESET0;
      endcase
    end
  end

endmodule

// File: rtl/top_mem.sv
// ROM at $F000-$FFFF, RAM at $0000-$01FF; combinational read, clocked write.
module hmc6502_mem
  import hmc6502_pkg::*;
#(
  parameter int ROM_WORDS = 4096,
  parameter int RAM_WORDS = 512
) (
  input  logic        i_clk,
  input  logic [15:0] i_addr,
  input  logic        i_we,
  input  logic [7:0]  i_wdata,
  output logic [7:0]  o_rdata
);
  localparam int ROM_AW = $clog2(ROM_WORDS);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam logic [15:0] RAM_LIMIT = 16'(RAM_WORDS);

  logic [7:0] ROM [0:ROM_WORDS-1];
  logic [7:0] RAM [0:RAM_WORDS-1];

  logic w_rom_sel, w_ram_sel;
  assign w_rom_sel = (i_addr >= ROM_BASE);
  assign w_ram_sel = (i_addr < RAM_LIMIT);

  always_comb begin
    o_rdata = 8'h00;
    if (w_rom_sel)      o_rdata = ROM[i_addr[ROM_AW-1:0]];
    else if (w_ram_sel) o_rdata = RAM[i_addr[RAM_AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_we && w_ram_sel) RAM[i_addr[RAM_AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/top.sv
// Subsystem top: wires the core to the ROM/RAM block; observed via hierarchy.
module top #(
  parameter int         ROM_WORDS = 4096,
  parameter int         RAM_WORDS = 512,
  parameter logic [7:0] RESET_SP  = 8'hFF
) (
  input logic ph1,
  input logic reset
);
  logic [15:0] w_addr;
  logic        w_we;
  logic [7:0]  w_wdata, w_rdata;

  hmc6502_core #(.RESET_SP(RESET_SP)) core (
    .i_clk   (ph1),
    .i_rst_n (reset),
    .i_rdata (w_rdata),
    .o_addr  (w_addr),
    .o_we    (w_we),
    .o_wdata (w_wdata)
  );

  hmc6502_mem #(.ROM_WORDS(ROM_WORDS), .RAM_WORDS(RAM_WORDS)) mem (
    .i_clk   (ph1),
    .i_addr  (w_addr),
    .i_we    (w_we),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_top.sv
// Bench for top: directed and random programs against an instruction-level model.
module tb_top;
  import hmc6502_pkg::*;

  logic ph1, reset;
  int   n_chk, n_err;

  logic [7:0]  rom_img  [0:4095];
  logic [7:0]  ram_init [0:511];
  logic [7:0]  ram_exp  [0:511];
  int          exp_cyc [$];
  logic [15:0] exp_pc  [$];
  logic [7:0]  ea, ex, es, ep;

  top dut (.ph1(ph1), .reset(reset));

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  function automatic logic [7:0] mrd(input logic [15:0] a);
    if (a >= 16'hF000) return rom_img[a[11:0]];
    if (a < 16'h0200)  return ram_exp[a[8:0]];
    return 8'h00;
  endfunction

  task automatic mwr(input logic [15:0] a, input logic [7:0] d);
    if (a < 16'h0200) ram_exp[a[8:0]] = d;
  endtask

  function automatic logic [7:0] nzf(input logic [7:0] p, input logic [7:0] v);
    return {v[7], p[6:2], (v == 8'h00), p[0]};
  endfunction

  task automatic new_image();
    for (int i = 0; i < 4096; i++) rom_img[i] = 8'h00;
    rom_img[4092] = 8'h00;
    rom_img[4093] = 8'hF0;
    for (int i = 0; i < 512; i++) ram_init[i] = 8'($urandom);
  endtask

  task automatic put_prog(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) rom_img[i] = b[i];
  endtask

  // ISA-level model: one instruction per step, timed from the cycle table
  task automatic model_run(input int ncyc);
    logic [15:0] pc;
    logic [7:0]  op, b1, b2;
    int c, cyc;
    for (int i = 0; i < 512; i++) ram_exp[i] = ram_init[i];
    exp_cyc.delete(); exp_pc.delete();
    ea = 8'h00; ex = 8'h00; es = 8'hFF; ep = 8'h24;
    pc = {rom_img[4093], rom_img[4092]};
    c = 2;
    while (c < ncyc) begin
      exp_cyc.push_back(c); exp_pc.push_back(pc);
      op = mrd(pc); b1 = mrd(pc + 16'd1); b2 = mrd(pc + 16'd2);
      cyc = 2;
      case (op)
        8'hA9: begin ea = b1; ep = nzf(ep, ea); pc = pc + 16'd2; end
        8'hA2: begin ex = b1; ep = nzf(ep, ex); pc = pc + 16'd2; end
        8'hA5: begin ea = mrd({8'h00, b1}); ep = nzf(ep, ea); pc = pc + 16'd2; cyc = 3; end
        8'h85: begin mwr({8'h00, b1}, ea); pc = pc + 16'd2; cyc = 3; end
        8'h8D: begin mwr({b2, b1}, ea); pc = pc + 16'd3; cyc = 4; end
        8'hAA: begin ex = ea; ep = nzf(ep, ex); pc = pc + 16'd1; end
        8'h8A: begin ea = ex; ep = nzf(ep, ea); pc = pc + 16'd1; end
        8'h9A: begin es = ex; pc = pc + 16'd1; end
        8'hBA: begin ex = es; ep = nzf(ep, ex); pc = pc + 16'd1; end
        8'h48: begin mwr({8'h01, es}, ea); es = es - 8'd1; pc = pc + 16'd1; cyc = 3; end
        8'h08: begin mwr({8'h01, es}, ep | 8'h30); es = es - 8'd1; pc = pc + 16'd1; cyc = 3; end
        8'h68: begin es = es + 8'd1; ea = mrd({8'h01, es}); ep = nzf(ep, ea); pc = pc + 16'd1; cyc = 4; end
        8'h28: begin es = es + 8'd1; ep = (mrd({8'h01, es}) | 8'h20) & 8'hEF; pc = pc + 16'd1; cyc = 4; end
        8'h4C: begin pc = {b2, b1}; cyc = 3; end
        default: pc = pc + 16'd1;
      endcase
      c = c + cyc;
    end
  endtask

  // Reset, optionally preload, release, then follow every fetch and the final state
  task automatic dut_run(input int ncyc, input bit reload);
    int k;
    logic is_f, want;
    reset = 1'b0;
    @(negedge ph1);
    if (reload) begin
      for (int i = 0; i < 4096; i++) dut.mem.ROM[i] = rom_img[i];
      for (int i = 0; i < 512; i++)  dut.mem.RAM[i] = ram_init[i];
    end
    @(negedge ph1);
    reset = 1'b1;
    k = 0;
    for (int c = 0; c < ncyc; c++) begin
      is_f = (dut.core.r_state == FETCH);
      want = 1'b0;
      if (k < exp_cyc.size()) want = (exp_cyc[k] == c);
      n_chk++;
      if (is_f !== want) begin
        n_err++;
        $display("FAIL fetch_timing cyc=%0d fetch=%0b expected=%0b", c, is_f, want);
      end else if (want) begin
        n_chk++;
        if (dut.core.r_pc !== exp_pc[k]) begin
          n_err++;
          $display("FAIL fetch_pc cyc=%0d pc=%h expected=%h", c, dut.core.r_pc, exp_pc[k]);
        end
      end
      if (want) k++;
      @(negedge ph1);
    end
    for (int i = 0; i < 512; i++) begin
      n_chk++;
      if (dut.mem.RAM[i] !== ram_exp[i]) begin
        n_err++;
        $display("FAIL ram[%h] got=%h expected=%h", i[8:0], dut.mem.RAM[i], ram_exp[i]);
      end
    end
    n_chk += 4;
    if (dut.core.r_a !== ea) begin n_err++; $display("FAIL reg_a got=%h expected=%h", dut.core.r_a, ea); end
    if (dut.core.r_x !== ex) begin n_err++; $display("FAIL reg_x got=%h expected=%h", dut.core.r_x, ex); end
    if (dut.core.r_s !== es) begin n_err++; $display("FAIL reg_s got=%h expected=%h", dut.core.r_s, es); end
    if (dut.core.r_p !== ep) begin n_err++; $display("FAIL reg_p got=%h expected=%h", dut.core.r_p, ep); end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    n_chk++;
    if (dut.core.r_a !== 8'h00 || dut.core.r_x !== 8'h00 || dut.core.r_s !== 8'hFF ||
        dut.core.r_p !== 8'h24 || dut.core.r_pc !== 16'h0000 || dut.core.r_state != RESET0) begin
      n_err++;
      $display("FAIL reset_state a=%h x=%h s=%h p=%h pc=%h expected 00 00 ff 24 0000",
               dut.core.r_a, dut.core.r_x, dut.core.r_s, dut.core.r_p, dut.core.r_pc);
    end
  endtask

  task automatic test_stack_roundtrip();
    new_image();
    put_prog({8'hA9, 8'h29, 8'h48, 8'hA9, 8'h00, 8'h68, 8'h85, 8'h30, 8'h4C, 8'h08, 8'hF0});
    model_run(40); dut_run(40, 1'b1);
    n_chk++;
    if (dut.mem.RAM[48] !== 8'h29 || dut.mem.RAM[511] !== 8'h29 || dut.core.r_s !== 8'hFF) begin
      n_err++;
      $display("FAIL roundtrip ram30=%h ram1ff=%h s=%h expected 29 29 ff",
               dut.mem.RAM[48], dut.mem.RAM[511], dut.core.r_s);
    end
  endtask

  task automatic test_transfers();
    new_image();
    put_prog({8'hA2, 8'h80, 8'h9A, 8'hA2, 8'h00, 8'hBA, 8'h8A, 8'h85, 8'h31, 8'h4C, 8'h09, 8'hF0});
    model_run(50); dut_run(50, 1'b1);
    n_chk++;
    if (dut.mem.RAM[49] !== 8'h80 || dut.core.r_s !== 8'h80 || dut.core.r_p[7] !== 1'b1 ||
        dut.core.r_p[1] !== 1'b0) begin
      n_err++;
      $display("FAIL transfers ram31=%h s=%h p=%h expected 80 80 N=1 Z=0",
               dut.mem.RAM[49], dut.core.r_s, dut.core.r_p);
    end
  endtask

  // Preamble pulls $00 into P so I is clear; then PLP leaves P=$22
  task automatic test_flag_stack();
    new_image();
    put_prog({8'hA9, 8'h00, 8'h48, 8'h28, 8'hA9, 8'h00, 8'h08, 8'hA9, 8'h01, 8'h28,
              8'h08, 8'h68, 8'h85, 8'h32, 8'h4C, 8'h0E, 8'hF0});
    model_run(70); dut_run(70, 1'b1);
    n_chk++;
    if (dut.mem.RAM[50] !== 8'h32) begin
      n_err++;
      $display("FAIL flag_stack ram32=%h expected=32", dut.mem.RAM[50]);
    end
  endtask

  task automatic test_stack_wrap();
    new_image();
    put_prog({8'hA2, 8'h00, 8'h9A, 8'hA9, 8'h5A, 8'h48, 8'h4C, 8'h06, 8'hF0});
    model_run(40); dut_run(40, 1'b1);
    n_chk++;
    if (dut.mem.RAM[256] !== 8'h5A || dut.core.r_s !== 8'hFF) begin
      n_err++;
      $display("FAIL wrap_push ram100=%h s=%h expected 5a ff", dut.mem.RAM[256], dut.core.r_s);
    end
    new_image();
    put_prog({8'hA2, 8'h00, 8'h9A, 8'hA9, 8'h5A, 8'h48, 8'h68, 8'h4C, 8'h07, 8'hF0});
    model_run(40); dut_run(40, 1'b1);
    n_chk++;
    if (dut.core.r_a !== 8'h5A || dut.core.r_s !== 8'h00) begin
      n_err++;
      $display("FAIL wrap_pull a=%h s=%h expected 5a 00", dut.core.r_a, dut.core.r_s);
    end
  endtask

  task automatic test_unknown_op();
    new_image();
    put_prog({8'hA9, 8'h77, 8'h02, 8'h85, 8'h33, 8'h4C, 8'h05, 8'hF0});
    model_run(40); dut_run(40, 1'b1);
    n_chk++;
    if (dut.mem.RAM[51] !== 8'h77) begin
      n_err++;
      $display("FAIL unknown_op ram33=%h expected=77", dut.mem.RAM[51]);
    end
  endtask

  // Cycle 6 after release is PHA's stack write; reset drops just before that edge
  task automatic test_reset_midrun();
    new_image();
    ram_init[511] = 8'h11;
    put_prog({8'hA9, 8'hAB, 8'h48, 8'h4C, 8'h03, 8'hF0});
    reset = 1'b0;
    @(negedge ph1);
    for (int i = 0; i < 4096; i++) dut.mem.ROM[i] = rom_img[i];
    for (int i = 0; i < 512; i++)  dut.mem.RAM[i] = ram_init[i];
    @(negedge ph1);
    reset = 1'b1;
    repeat (6) @(negedge ph1);
    n_chk++;
    if (dut.core.r_state != STACK_RW) begin
      n_err++;
      $display("FAIL midrun_state state=%0d expected STACK_RW", dut.core.r_state);
    end
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (dut.core.r_a !== 8'h00 || dut.core.r_x !== 8'h00 || dut.core.r_s !== 8'hFF ||
        dut.core.r_p !== 8'h24) begin
      n_err++;
      $display("FAIL midrun_regs a=%h x=%h s=%h p=%h expected 00 00 ff 24",
               dut.core.r_a, dut.core.r_x, dut.core.r_s, dut.core.r_p);
    end
    @(posedge ph1);
    #1;
    n_chk++;
    if (dut.mem.RAM[511] !== 8'h11) begin
      n_err++;
      $display("FAIL midrun_nowrite ram1ff=%h expected=11", dut.mem.RAM[511]);
    end
    model_run(40); dut_run(40, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0]  ops [0:15];
    logic [7:0]  op;
    logic [15:0] t;
    int n, a;
    ops = '{8'hA9, 8'hA2, 8'hA5, 8'h85, 8'h8D, 8'hAA, 8'h8A, 8'h9A,
            8'hBA, 8'h48, 8'h68, 8'h08, 8'h28, 8'hEA, 8'h02, 8'hFF};
    for (int r = 0; r < 8; r++) begin
      new_image();
      n = $urandom_range(25, 10);
      a = 0;
      repeat (n) begin
        op = ops[$urandom_range(15, 0)];
        rom_img[a] = op; a++;
        if (op == 8'hA9 || op == 8'hA2 || op == 8'hA5 || op == 8'h85) begin
          rom_img[a] = 8'($urandom); a++;
        end else if (op == 8'h8D) begin
          case ($urandom_range(2, 0))
            0:       t = 16'($urandom_range(511, 0));
            1:       t = 16'hF000 | 16'($urandom_range(4095, 0));
            default: t = 16'h0400;
          endcase
          rom_img[a] = t[7:0]; rom_img[a+1] = t[15:8]; a += 2;
        end
      end
      t = 16'hF000 + 16'(a);
      rom_img[a] = 8'h4C; rom_img[a+1] = t[7:0]; rom_img[a+2] = t[15:8];
      model_run(200); dut_run(200, 1'b1);
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    reset = 1'b1;
    test_reset();
    test_stack_roundtrip();
    test_transfers();
    test_flag_stack();
    test_stack_wrap();
    test_unknown_op();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/top.md
Name: top

Overview:
- Minimal 6502-subset processor subsystem: an 8-bit multi-cycle CPU core plus an on-chip memory block (4 KB ROM, 512 B RAM).
- Top-level integration unit for instruction-level regression programs. Test programs are preloaded into ROM. Results are checked by reading RAM hierarchically after a fixed number of cycles.
- Focus subset: load/store, transfers, and stack operations, including the hardware stack in page $01.

Parameters:
- ROM_WORDS, 4096: ROM depth in bytes; ROM is mapped at $F000–$FFFF.
- RAM_WORDS, 512: RAM depth in bytes; RAM is mapped at $0000–$01FF (zero page plus stack page).
- RESET_SP, 8'hFF: stack pointer value after reset.

Ports:
- ph1  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- No other ports; observation is through hierarchy only.

Behaviour:
Hierarchy and memory:
- Memory instance is named mem, with arrays ROM[0:4095] and RAM[0:511], 8-bit entries. These names are fixed for bench preload and inspection.
- Reads are combinational.
  - Addresses $F000–$FFFF read ROM[addr[11:0]].
  - Addresses $0000–$01FF read RAM[addr[8:0]].
  - All other addresses read $00.
- Writes are synchronous on ph1.
  - Writes to $0000–$01FF only; ROM writes are ignored.

Reset and vector fetch:
- While reset=0: A=X=0, S=RESET_SP, P=8'h24 (I=1, bit5=1), PC=0, state=RESET0, no memory writes.
- After release:
  - RESET0 reads $FFFC into PCL.
  - RESET1 reads $FFFD into PCH.
  - FETCH follows.
- Total of 2 cycles before the first opcode fetch. With the standard vector (ROM[4092]=$00, ROM[4093]=$F0), execution starts at $F000.
- Reset asserted mid-instruction aborts immediately. No partial write may occur in the cycle reset is low.

Registers and flags:
- Registers: A, X, S (8-bit); PC (16-bit); P = {N,V,1,B,D,I,Z,C}.
- Stack address is {8'h01, S}.
  - Push: write, then S−1.
  - Pull: S+1, then read.
  - S wraps modulo 256 with no fault.

Instruction subset and cycle counts (cycles include the opcode fetch):
- LDA #imm $A9, 2
- LDX #imm $A2, 2
- LDA zp $A5, 3
- STA zp $85, 3
- STA abs $8D, 4
- TAX $AA, 2
- TXA $8A, 2
- TXS $9A, 2
- TSX $BA, 2
- PHA $48, 3
- PLA $68, 4
- PHP $08, 3
- PLP $28, 4
- JMP abs $4C, 3
- NOP $EA, 2

Flag rules:
- N and Z are updated by LDA, LDX, TAX, TXA, TSX and PLA.
- TXS and stores affect no flags.
- PHP pushes P with bits 5 and 4 forced to 1.
- PLP loads P from the stack, with bit5 forced to 1 and bit4 forced to 0.

Other rules:
- Any other opcode executes as a 1-byte, 2-cycle NOP.
- PC increments past every operand byte.
- PC wraps from $FFFF to $0000.

Decomposition:
- Package hmc6502_pkg holds:
  - opcode localparams;
  - state enum: RESET0, RESET1, FETCH, OPER_LO, OPER_HI, STACK_INC, STACK_RW, EXEC;
  - P bit-index constants;
  - address-map constants.
- Sub-modules:
  - core: datapath plus FSM.
  - mem: ROM/RAM with the fixed instance and array names.
- top only wires core to mem.

Test Plan:
- Stack round-trip: program LDA #$29, PHA, LDA #$00, PLA, STA $30, JMP self at $F000; vector $F000; release reset, run 40 cycles → RAM[48]=$29, RAM[$1FF]=$29, S=$FF.
- Transfers: LDX #$80, TXS, LDX #$00, TSX, TXA, STA $31 → RAM[$31]=$80, S=$80, N=1, Z=0.
- Flag stack: LDA #$00 (Z=1), PHP, LDA #$01 (Z=0), PLP, PHP, PLA, STA $32 → RAM[$32]=$32 (P=$22 after PLP; pushed with bit4 and bit5 set gives $32), Z=1 after PLP.
- Stack wrap: LDX #$00, TXS, LDA #$5A, PHA → RAM[$100]=$5A, S=$FF; then PLA → A=$5A, S=$00.
- Reset mid-run: assert reset low during a PHA write cycle → no RAM change that cycle; A=X=0, S=$FF, P=$24. After release, the program restarts from vector $F000 and its first opcode fetch occurs 2 cycles later.
- Unknown opcode $02 followed by STA $33 (A from a prior LDA #$77) → RAM[$33]=$77; $02 consumes exactly 2 cycles and 1 byte.
